// File: rtl/cmd_executor_if.sv
// Register-write handshake between the command executor and the motion core.
// The executor drives address/data/strobe; the core pushes back with busy.
interface cmd_executor_if #(
    parameter int DATA_W = 32
);
    logic [5:0]        ext_out_reg_addr;
    logic [DATA_W-1:0] ext_out_reg_data;
    logic              ext_out_reg_stb;
    logic              ext_out_reg_busy;

    modport master (
        output ext_out_reg_addr, ext_out_reg_data, ext_out_reg_stb,
        input  ext_out_reg_busy
    );

    modport slave (
        input  ext_out_reg_addr, ext_out_reg_data, ext_out_reg_stb,
        output ext_out_reg_busy
    );
endinterface

// File: rtl/cmd_executor.sv
// Buffered command executor: host fills a command RAM, then the block fetches and
// runs register writes, strobes, interrupt waits/clears, jumps and counted loops.
module cmd_executor #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int NINT   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    cmd_executor_if.master      out_reg,
    output logic [DATA_W-1:0]   ext_out_stbs,
    input  logic [NINT-1:0]     ext_pending_ints,
    output logic [NINT-1:0]     ext_clear_ints,
    input  logic [ADDR_W-1:0]   ext_buffer_addr,
    input  logic [DATA_W+7:0]   ext_buffer_data,
    input  logic                ext_buffer_wr,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic                abort,
    output logic                running,
    output logic                complete,
    output logic [ADDR_W-1:0]   pc,
    output logic [7:0]          error
);
    localparam int IW = DATA_W + 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;

    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_MISC = 2'b10;

    localparam logic [5:0] SUB_NOP   = 6'd0;
    localparam logic [5:0] SUB_STB   = 6'd1;
    localparam logic [5:0] SUB_WALL  = 6'd2;
    localparam logic [5:0] SUB_WANY  = 6'd3;
    localparam logic [5:0] SUB_CLR   = 6'd4;
    localparam logic [5:0] SUB_JUMP  = 6'd5;
    localparam logic [5:0] SUB_LINIT = 6'd6;
    localparam logic [5:0] SUB_LOOP  = 6'd7;
    localparam logic [5:0] SUB_STMO  = 6'd8;
    localparam logic [5:0] SUB_DONE  = 6'd63;

    localparam logic [7:0] ERR_DONE  = 8'h7F;
    localparam logic [7:0] ERR_ILL   = 8'h81;
    localparam logic [7:0] ERR_ABORT = 8'h82;
    localparam logic [7:0] ERR_TMO   = 8'h83;
    localparam logic [7:0] ERR_PC    = 8'h84;

    logic [IW-1:0]     r_mem [0:(1<<ADDR_W)-1];
    logic [IW-1:0]     r_rdata;
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_error;
    logic              r_complete;
    logic [5:0]        r_reg_addr;
    logic [DATA_W-1:0] r_reg_data;
    logic              r_reg_stb;
    logic [DATA_W-1:0] r_stbs;
    logic [NINT-1:0]   r_clr;
    logic [DATA_W-1:0] r_loop_cnt;
    logic [DATA_W-1:0] r_timeout_lim;
    logic [DATA_W-1:0] r_wait_cnt;

    // Read-first RAM: the read port always tracks pc, so it is valid in S_DECODE.
    always_ff @(posedge clk) begin
        if (ext_buffer_wr) r_mem[ext_buffer_addr] <= ext_buffer_data;
        r_rdata <= r_mem[r_pc];
    end

    logic [1:0]        w_op;
    logic [5:0]        w_sub;
    logic [DATA_W-1:0] w_d;
    logic [NINT-1:0]   w_mask;
    logic              w_all, w_any, w_tmo;
    logic              w_adv, w_jump, w_halt, w_wr, w_stb, w_clr;
    logic              w_linit, w_ldec, w_stmo, w_winc;
    logic [7:0]        w_code;

    assign w_op   = r_rdata[IW-1:IW-2];
    assign w_sub  = r_rdata[IW-3:IW-8];
    assign w_d    = r_rdata[DATA_W-1:0];
    assign w_mask = w_d[NINT-1:0];
    assign w_all  = (ext_pending_ints & w_mask) == w_mask;
    assign w_any  = |(ext_pending_ints & w_mask);
    assign w_tmo  = (r_timeout_lim != '0) && (r_wait_cnt == r_timeout_lim - DATA_W'(1));

    always_comb begin
        w_adv = 1'b0; w_jump = 1'b0; w_halt = 1'b0; w_code = 8'h00;
        w_wr = 1'b0; w_stb = 1'b0; w_clr = 1'b0;
        w_linit = 1'b0; w_ldec = 1'b0; w_stmo = 1'b0; w_winc = 1'b0;
        case (w_op)
            OP_WR: begin
                if (!out_reg.ext_out_reg_busy) begin
                    w_wr  = 1'b1;
                    w_adv = 1'b1;
                end
            end
            OP_MISC: begin
                case (w_sub)
                    SUB_NOP:   w_adv = 1'b1;
                    SUB_STB:   begin w_stb = 1'b1; w_adv = 1'b1; end
                    SUB_WALL, SUB_WANY: begin
                        // satisfied condition beats the timeout in the same cycle
                        if ((w_sub == SUB_WALL) ? w_all : w_any) w_adv = 1'b1;
                        else if (w_tmo) begin w_halt = 1'b1; w_code = ERR_TMO; end
                        else w_winc = 1'b1;
                    end
                    SUB_CLR:   begin w_clr = 1'b1; w_adv = 1'b1; end
                    SUB_JUMP:  w_jump = 1'b1;
                    SUB_LINIT: begin w_linit = 1'b1; w_adv = 1'b1; end
                    SUB_LOOP: begin
                        if (r_loop_cnt != '0) begin w_ldec = 1'b1; w_jump = 1'b1; end
                        else w_adv = 1'b1;
                    end
                    SUB_STMO:  begin w_stmo = 1'b1; w_adv = 1'b1; end
                    SUB_DONE:  begin w_halt = 1'b1; w_code = ERR_DONE; end
                    default:   begin w_halt = 1'b1; w_code = ERR_ILL; end
                endcase
            end
            default: begin w_halt = 1'b1; w_code = ERR_ILL; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_error       <= '0;
            r_complete    <= 1'b0;
            r_reg_addr    <= '0;
            r_reg_data    <= '0;
            r_reg_stb     <= 1'b0;
            r_stbs        <= '0;
            r_clr         <= '0;
            r_loop_cnt    <= '0;
            r_timeout_lim <= '0;
            r_wait_cnt    <= '0;
        end else begin
            r_reg_stb  <= 1'b0;
            r_stbs     <= '0;
            r_clr      <= '0;
            r_complete <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_pc          <= start_addr;
                    r_error       <= '0;
                    r_loop_cnt    <= '0;
                    r_timeout_lim <= '0;
                    r_state       <= S_FETCH;
                end
            end else if (abort) begin
                r_error    <= ERR_ABORT;
                r_complete <= 1'b1;
                r_state    <= S_IDLE;
            end else if (r_state == S_FETCH) begin
                r_wait_cnt <= '0;
                r_state    <= S_DECODE;
            end else begin
                if (w_wr) begin
                    r_reg_addr <= w_sub;
                    r_reg_data <= w_d;
                    r_reg_stb  <= 1'b1;
                end
                if (w_stb)   r_stbs        <= w_d;
                if (w_clr)   r_clr         <= w_mask;
                if (w_linit) r_loop_cnt    <= w_d;
                if (w_ldec)  r_loop_cnt    <= r_loop_cnt - DATA_W'(1);
                if (w_stmo)  r_timeout_lim <= w_d;
                if (w_winc)  r_wait_cnt    <= r_wait_cnt + DATA_W'(1);

                if (w_halt) begin
                    r_error    <= w_code;
                    r_complete <= 1'b1;
                    r_state    <= S_IDLE;
                end else if (w_jump) begin
                    r_pc    <= w_d[ADDR_W-1:0];
                    r_state <= S_FETCH;
                end else if (w_adv) begin
                    // running off the end of the RAM halts with pc left on the last word
                    if (&r_pc) begin
                        r_error    <= ERR_PC;
                        r_complete <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_state <= S_FETCH;
                    end
                end
            end
        end
    end

    assign out_reg.ext_out_reg_addr = r_reg_addr;
    assign out_reg.ext_out_reg_data = r_reg_data;
    assign out_reg.ext_out_reg_stb  = r_reg_stb;
    assign ext_out_stbs             = r_stbs;
    assign ext_clear_ints           = r_clr;
    assign running                  = (r_state != S_IDLE);
    assign complete                 = r_complete;
    assign pc                       = r_pc;
    assign error                    = r_error;
endmodule

// File: tb/tb_cmd_executor.sv
// Directed bench for cmd_executor: expected output events go to a scoreboard queue
// as each program is launched and are popped by a monitor as the pulses appear.
module tb_cmd_executor;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int NINT   = 8;

    localparam int K_REG = 0;
    localparam int K_STB = 1;
    localparam int K_CLR = 2;
    localparam int K_CMP = 3;

    typedef struct {
        int          kind;
        logic [63:0] val;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] ext_out_stbs;
    logic [NINT-1:0]   ext_pending_ints = '0;
    logic [NINT-1:0]   ext_clear_ints;
    logic [ADDR_W-1:0] ext_buffer_addr = '0;
    logic [DATA_W+7:0] ext_buffer_data = '0;
    logic              ext_buffer_wr = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              abort = 1'b0;
    logic              running, complete;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        error;

    cmd_executor_if #(.DATA_W(DATA_W)) bus ();

    cmd_executor #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NINT(NINT)) dut (
        .clk(clk), .rst_n(rst_n), .out_reg(bus),
        .ext_out_stbs(ext_out_stbs), .ext_pending_ints(ext_pending_ints),
        .ext_clear_ints(ext_clear_ints), .ext_buffer_addr(ext_buffer_addr),
        .ext_buffer_data(ext_buffer_data), .ext_buffer_wr(ext_buffer_wr),
        .start(start), .start_addr(start_addr), .abort(abort),
        .running(running), .complete(complete), .pc(pc), .error(error)
    );

    always #5 clk = ~clk;

    int  errors = 0;
    int  checks = 0;
    bit  mon_en = 1'b1;
    ev_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [63:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input int k, input logic [63:0] v);
        ev_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected_event_kind", 64'(k), 64'hFFFF);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", 64'(k), 64'(e.kind));
            chk("sb_value", v, e.val);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                if (bus.ext_out_reg_stb)
                    sb_pop(K_REG, {26'd0, bus.ext_out_reg_addr, bus.ext_out_reg_data});
                if (ext_out_stbs != '0)   sb_pop(K_STB, 64'(ext_out_stbs));
                if (ext_clear_ints != '0) sb_pop(K_CLR, 64'(ext_clear_ints));
                if (complete)             sb_pop(K_CMP, 64'(error));
            end
        end
    endtask

    function automatic logic [DATA_W+7:0] ins(input logic [1:0] op, input logic [5:0] sub,
                                              input logic [DATA_W-1:0] d);
        return {op, sub, d};
    endfunction

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W+7:0] d);
        @(negedge clk);
        ext_buffer_wr   = 1'b1;
        ext_buffer_addr = a;
        ext_buffer_data = d;
        @(negedge clk);
        ext_buffer_wr   = 1'b0;
    endtask

    // Returns on the negedge right after the start edge (block is in fetch).
    task automatic go(input logic [ADDR_W-1:0] a);
        @(negedge clk);
        start      = 1'b1;
        start_addr = a;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_complete(input string tag, input int maxc, output int n);
        n = 0;
        while (!complete && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(complete), 64'd1);
    endtask

    int n;

    initial begin
        bus.ext_out_reg_busy = 1'b0;
        fork monitor(); join_none

        // reset state
        #12;
        chk("rst_running", 64'(running), 0);
        chk("rst_complete", 64'(complete), 0);
        chk("rst_pc", 64'(pc), 0);
        chk("rst_error", 64'(error), 0);
        chk("rst_reg_stb", 64'(bus.ext_out_reg_stb), 0);
        chk("rst_reg_addr_data", {bus.ext_out_reg_addr, bus.ext_out_reg_data}, 0);
        chk("rst_stbs_clr", {ext_out_stbs, ext_clear_ints}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single register write then DONE
        wr(0, ins(2'b01, 6'd5, 32'h12345678));
        wr(1, ins(2'b10, 6'd63, 32'h0));
        push(K_REG, {26'd0, 6'd5, 32'h12345678});
        push(K_CMP, 64'h7F);
        go(0);
        chk("wr_running", 64'(running), 1);
        @(negedge clk);
        chk("wr_stb_cycle2", 64'(bus.ext_out_reg_stb), 0);
        @(negedge clk);
        chk("wr_stb_cycle3", 64'(bus.ext_out_reg_stb), 1);
        chk("wr_addr", 64'(bus.ext_out_reg_addr), 5);
        chk("wr_data", 64'(bus.ext_out_reg_data), 64'h12345678);
        wait_complete("wr_complete", 20, n);
        chk("wr_error", 64'(error), 64'h7F);
        @(negedge clk);
        chk("wr_running_low", 64'(running), 0);
        chk("wr_addr_held", 64'(bus.ext_out_reg_addr), 5);

        // busy stall for 10 cycles
        wr(0, ins(2'b01, 6'd9, 32'hA5));
        push(K_REG, {26'd0, 6'd9, 32'hA5});
        push(K_CMP, 64'h7F);
        bus.ext_out_reg_busy = 1'b1;
        go(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("busy_no_stb", 64'(bus.ext_out_reg_stb), 0);
            chk("busy_pc_held", 64'(pc), 0);
        end
        bus.ext_out_reg_busy = 1'b0;
        @(negedge clk);
        chk("busy_stb_after_release", 64'(bus.ext_out_reg_stb), 1);
        wait_complete("busy_complete", 20, n);

        // counted loop: body runs N+1 times
        wr(0, ins(2'b10, 6'd6, 32'd3));
        wr(1, ins(2'b10, 6'd1, 32'h1));
        wr(2, ins(2'b10, 6'd7, 32'd1));
        wr(3, ins(2'b10, 6'd63, 32'h0));
        for (int i = 0; i < 4; i++) push(K_STB, 64'h1);
        push(K_CMP, 64'h7F);
        go(0);
        wait_complete("loop_complete", 200, n);
        chk("loop_error", 64'(error), 64'h7F);
        @(negedge clk);
        chk("loop_sb_drained", 64'(sb.size()), 0);

        // wait timeout
        wr(0, ins(2'b10, 6'd8, 32'd20));
        wr(1, ins(2'b10, 6'd2, 32'h3));
        wr(2, ins(2'b10, 6'd63, 32'h0));
        ext_pending_ints = 8'h01;
        push(K_CMP, 64'h83);
        go(0);
        wait_complete("tmo_complete", 100, n);
        chk("tmo_latency", 64'(n), 23);
        chk("tmo_error", 64'(error), 64'h83);
        chk("tmo_pc", 64'(pc), 1);

        // same program, condition met before the timeout
        push(K_CMP, 64'h7F);
        go(0);
        repeat (8) @(negedge clk);
        ext_pending_ints = 8'h03;
        wait_complete("wait_ok_complete", 100, n);
        chk("wait_ok_error", 64'(error), 64'h7F);
        chk("wait_ok_pc", 64'(pc), 2);
        ext_pending_ints = 8'h00;

        // jump + clear ints; abort raised together with start is ignored
        wr(0, ins(2'b10, 6'd5, 32'd5));
        wr(5, ins(2'b10, 6'd4, 32'hF0));
        wr(6, ins(2'b10, 6'd63, 32'h0));
        push(K_CLR, 64'hF0);
        push(K_CMP, 64'h7F);
        @(negedge clk);
        start = 1'b1; abort = 1'b1; start_addr = 0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        wait_complete("jump_complete", 50, n);
        chk("jump_error", 64'(error), 64'h7F);
        chk("jump_pc", 64'(pc), 6);

        // illegal encodings
        wr(0, ins(2'b11, 6'd0, 32'h0));
        push(K_CMP, 64'h81);
        go(0);
        wait_complete("ill_op_complete", 20, n);
        chk("ill_op_error", 64'(error), 64'h81);
        wr(0, ins(2'b10, 6'd9, 32'h0));
        push(K_CMP, 64'h81);
        go(0);
        wait_complete("ill_sub_complete", 20, n);
        chk("ill_sub_error", 64'(error), 64'h81);

        // pc overflow at the last word
        wr(15, ins(2'b10, 6'd0, 32'h0));
        push(K_CMP, 64'h84);
        go(15);
        wait_complete("ovf_complete", 20, n);
        chk("ovf_error", 64'(error), 64'h84);
        chk("ovf_pc", 64'(pc), 15);

        // abort during a wait
        wr(0, ins(2'b10, 6'd3, 32'h80));
        push(K_CMP, 64'h82);
        go(0);
        repeat (5) @(negedge clk);
        chk("abort_still_running", 64'(running), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_complete", 64'(complete), 1);
        chk("abort_error", 64'(error), 64'h82);
        chk("abort_running", 64'(running), 0);
        chk("abort_pc", 64'(pc), 0);

        // async reset mid-run, then silence
        wr(0, ins(2'b10, 6'd6, 32'd100));
        wr(1, ins(2'b10, 6'd1, 32'h2));
        wr(2, ins(2'b10, 6'd7, 32'd1));
        @(negedge clk);
        mon_en = 1'b0;
        go(0);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_running", 64'(running), 0);
        chk("arst_pc_error", {pc, error}, 0);
        chk("arst_pulses", {bus.ext_out_reg_stb, complete, ext_out_stbs, ext_clear_ints}, 0);
        repeat (3) @(negedge clk);
        sb.delete();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("arst_idle", 64'(running), 0);
        chk("final_sb_empty", 64'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cmd_executor.md
Name: cmd_executor

Overview:
- Parametrised successor to the buffered command executor in the 3dp_motion host-to-motion path.
- Host loads a command RAM, then pulses start; the block fetches and executes instructions:
  - register writes to the motion core over the out_reg handshake
  - strobe pulses
  - interrupt waits and clears
- Adds over the previous generation:
  - configurable depth and data width
  - JUMP and counted LOOP instructions
  - wait timeout
  - PC-overflow detection
  - registered single-cycle output pulses

Parameters:
ADDR_W, 10, command RAM address width; depth = 2**ADDR_W words
DATA_W, 32, payload width; instruction word width IW = DATA_W+8
NINT, 32, number of interrupt lines (NINT <= DATA_W)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ext_out_reg_addr  out  6  register address to motion core
ext_out_reg_data  out  DATA_W  register data
ext_out_reg_stb  out  1  write strobe, one cycle
ext_out_reg_busy  in  1  core cannot accept a write
ext_out_stbs  out  DATA_W  strobe pulses, one cycle
ext_pending_ints  in  NINT  pending interrupt flags
ext_clear_ints  out  NINT  interrupt clear pulses, one cycle
ext_buffer_addr  in  ADDR_W  host RAM write address
ext_buffer_data  in  IW  host RAM write data
ext_buffer_wr  in  1  host RAM write enable
start  in  1  begin execution at start_addr (honoured in S_IDLE only)
start_addr  in  ADDR_W  first instruction address
abort  in  1  stop immediately
running  out  1  high in any state except S_IDLE
complete  out  1  one-cycle pulse on halt (DONE, error, abort)
pc  out  ADDR_W  current instruction address
error  out  8  status code, held until next accepted start

Behaviour:
- Reset (rst_n low, async) clears to 0: all outputs, pc, loop_cnt, timeout_lim, wait_cnt; state <= S_IDLE. RAM contents are not reset.
- RAM: one write port (host) and one registered read port at pc. Read-first: a same-cycle write to pc returns old data.
- Instruction fields:
  - op = [IW-1:IW-2]
  - sub/addr = [IW-3:IW-8]
  - payload D = [DATA_W-1:0]
- States:
  - S_IDLE: start -> pc<=start_addr, error<=0, loop_cnt<=0, timeout_lim<=0, S_FETCH.
  - S_FETCH: one cycle for the RAM read -> S_DECODE.
  - S_DECODE: execute the instruction. Non-stalling instructions take 2 cycles each.
- Outputs:
  - stb, stbs, clear_ints and complete are registered; each asserts in the cycle after the decoding cycle, for exactly one cycle.
  - ext_out_reg_addr/data hold their last value.
- op=01 WRITE_REG:
  - If busy is high, stall in S_DECODE.
  - Otherwise addr<=sub, data<=D, stb pulse, pc+1.
- op=10 MISC, by sub:
  - 0 NOP: pc+1.
  - 1 STB: ext_out_stbs<=D pulse; pc+1.
  - 2 WAIT_ALL: proceed (pc+1) when (ints & D[NINT-1:0]) == D[NINT-1:0].
  - 3 WAIT_ANY: proceed (pc+1) when (ints & D[NINT-1:0]) != 0.
  - 4 CLEAR_INTS: ext_clear_ints<=D[NINT-1:0] pulse; pc+1.
  - 5 JUMP: pc<=D[ADDR_W-1:0].
  - 6 LOOP_INIT: loop_cnt<=D; pc+1.
  - 7 LOOP: if loop_cnt!=0 then loop_cnt-1 and pc<=D[ADDR_W-1:0]; else pc+1. Body between LOOP_INIT N and LOOP therefore runs N+1 times.
  - 8 SET_TIMEOUT: timeout_lim<=D; pc+1 (0 = wait forever).
  - 63 DONE: error<=8'h7F, complete, S_IDLE.
  - Any other sub: illegal.
- op=00 or 11: illegal -> error<=8'h81, complete, S_IDLE.
- Waits:
  - wait_cnt clears on entering S_DECODE and increments for each unsatisfied cycle.
  - If timeout_lim!=0 and wait_cnt==timeout_lim-1 while still unsatisfied -> error<=8'h83, complete, S_IDLE.
  - A satisfied condition in the same cycle wins over the timeout.
- PC overflow: an instruction that would advance pc+1 from 2**ADDR_W-1 -> error<=8'h84, complete, S_IDLE; pc holds. JUMP and LOOP branches never overflow.
- abort:
  - In any non-idle state it has priority over everything: error<=8'h82, complete, S_IDLE; pc is held for debug.
  - Ignored in S_IDLE.
  - abort and start together in S_IDLE: start is taken.
- start while running: ignored.
- Async reset mid-instruction: no output pulses are emitted afterwards.

Test Plan:
- WRITE_REG addr 5, D=0x12345678, then DONE, start_addr=0 -> stb at cycle 3 after start with addr 5, data 0x12345678; complete with error 0x7F; running drops.
- busy held high 10 cycles during WRITE_REG -> no stb and pc stays 0 for those 10 cycles; stb exactly one cycle after busy falls.
- LOOP_INIT 3, STB D=1, LOOP to 1, DONE -> exactly 4 ext_out_stbs pulses of 0x1, then complete with error 0x7F.
- SET_TIMEOUT 20, WAIT_ALL D=0x3 with ints=0x1 -> error 0x83 at wait cycle 20. Repeat with ints=0x3 raised at wait cycle 5 -> proceeds; no error.
- Instruction op=11, or MISC sub=9 -> error 0x81 and complete. NOP at address 2**ADDR_W-1 -> error 0x84.
- abort during a WAIT -> error 0x82 and complete the next cycle. rst_n low mid-run -> all outputs 0 immediately, with no clk edge needed.
